// File: rtl/pkt_arb_pkg.sv
// Shared types and flit-field helpers for the packet round-robin arbiter.
// Flit control bits sit at the top of each quarter: valid, sop, eop (descending).
package pkt_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_e;

  // Widest flit the head/tail helpers accept; narrower flits are zero-extended.
  localparam int unsigned PKT_MAX_W = 2048;

  function automatic int unsigned q_valid_bit(input int unsigned w, input int unsigned q);
    return (q + 1) * w / 4 - 1;
  endfunction

  function automatic int unsigned q_sop_bit(input int unsigned w, input int unsigned q);
    return (q + 1) * w / 4 - 2;
  endfunction

  function automatic int unsigned q_eop_bit(input int unsigned w, input int unsigned q);
    return (q + 1) * w / 4 - 3;
  endfunction

  // Only the quarter-3 sop bit marks a packet head.
  function automatic logic head(input logic [PKT_MAX_W-1:0] flit, input int unsigned w);
    logic [PKT_MAX_W-1:0] s;
    s = flit >> q_sop_bit(w, 3);
    return s[0];
  endfunction

  // Any quarter's eop bit marks a packet tail.
  function automatic logic tail(input logic [PKT_MAX_W-1:0] flit, input int unsigned w);
    logic [PKT_MAX_W-1:0] s;
    logic t;
    t = 1'b0;
    for (int unsigned q = 0; q < 4; q++) begin
      s = flit >> q_eop_bit(w, q);
      t = t | s[0];
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first: searches upward from ptr+1 with wraparound,
// optionally skipping mask_idx.
module rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [IW-1:0] mask_idx,
  input  logic          mask_en,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!gnt_valid && req[cand] && !(mask_en && (cand == mask_idx))) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-locking round-robin arbiter: one output shared by NUM_IN flit sources.
// Optional flit watchdog enabled by defining PKT_ARB_WDOG_EN.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned NOC_WIDTH     = 600,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned NOC_RADIX     = 16,
  parameter int unsigned MAX_PKT_FLITS = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN*NOC_WIDTH-1:0] i_data_in,
  input  logic [NUM_IN-1:0]           i_valid_in,
  output logic [NUM_IN-1:0]           i_ready_out,
  output logic [NOC_WIDTH-1:0]        o_data_out,
  output logic                        o_valid_out,
  input  logic                        o_ready_in,
  output logic [$clog2(NUM_IN)-1:0]   o_owner,
  output logic                        o_busy,
  output logic                        o_wdog_err
);

  localparam int unsigned OW = $clog2(NUM_IN);

  arb_state_e state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;

  logic [NOC_WIDTH-1:0] flits [NUM_IN];
  logic [NOC_WIDTH-1:0] owner_flit;
  logic [NUM_IN-1:0]    req;
  logic                 owner_xfer;
  logic                 owner_tail;
  logic                 wdog_hit;
  logic                 release_pkt;
  logic                 grant;

  logic          pick_mask;
  logic [OW-1:0] pick_ptr;
  logic          gnt_valid;
  logic [OW-1:0] gnt_idx;

  // Header field widths are only carried for the surrounding NoC bookkeeping.
  logic unused_cfg;
  assign unused_cfg = ^{32'(NUM_VC), 32'(NOC_RADIX)};

  always_comb begin
    for (int k = 0; k < int'(NUM_IN); k++) begin
      flits[k] = i_data_in[k*NOC_WIDTH +: NOC_WIDTH];
      req[k]   = i_valid_in[k] && head(PKT_MAX_W'(flits[k]), NOC_WIDTH);
    end
  end

  assign owner_flit  = flits[owner_q];
  assign owner_tail  = tail(PKT_MAX_W'(owner_flit), NOC_WIDTH);
  assign owner_xfer  = (state_q == BUSY) && i_valid_in[owner_q] && o_ready_in;
  assign release_pkt = owner_xfer && (owner_tail || wdog_hit);

  // During handover the pointer moves to the retiring owner and the owner is
  // excluded, since its current flit is the tail being consumed.
  assign pick_mask = (state_q == BUSY);
  assign pick_ptr  = (state_q == BUSY) ? owner_q : ptr_q;

  rr_picker #(
    .N(NUM_IN)
  ) u_picker (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_idx (owner_q),
    .mask_en  (pick_mask),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = BUSY;
          grant   = 1'b1;
        end
      end
      BUSY: begin
        if (release_pkt) begin
          ptr_d = owner_q;
          if (gnt_valid) begin
            owner_d = gnt_idx;
            grant   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= OW'(NUM_IN - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    o_data_out  = '0;
    o_valid_out = 1'b0;
    i_ready_out = '0;
    if (state_q == BUSY) begin
      o_data_out           = owner_flit;
      o_valid_out          = i_valid_in[owner_q];
      i_ready_out[owner_q] = o_ready_in;
    end
  end

  assign o_busy  = (state_q == BUSY);
  assign o_owner = owner_q;

`ifdef PKT_ARB_WDOG_EN
  localparam int unsigned CW = $clog2(MAX_PKT_FLITS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wdog_q;

  // Fires on the transfer that would make MAX_PKT_FLITS flits without a tail.
  assign wdog_hit = owner_xfer && !owner_tail && (cnt_q == CW'(MAX_PKT_FLITS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      cnt_d = '0;
    end else if (owner_xfer) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= wdog_hit;
    end
  end

  assign o_wdog_err = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^32'(MAX_PKT_FLITS);
  assign wdog_hit    = 1'b0;
  assign o_wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: directed vector table, hand-built reset/watchdog
// sequences, then randomized packet sources checked against a reference model.
module tb_pkt_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 600;
  localparam int MaxFl = 4;
`ifdef PKT_ARB_WDOG_EN
  localparam bit Wdog = 1'b1;
`else
  localparam bit Wdog = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] i_data_in;
  logic [N-1:0]   i_valid_in;
  logic [N-1:0]   i_ready_out;
  logic [W-1:0]   o_data_out;
  logic           o_valid_out;
  logic           o_ready_in;
  logic [1:0]     o_owner;
  logic           o_busy;
  logic           o_wdog_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pkt_rr_arbiter #(
    .NUM_IN       (N),
    .NOC_WIDTH    (W),
    .NUM_VC       (2),
    .NOC_RADIX    (16),
    .MAX_PKT_FLITS(MaxFl)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_data_in  (i_data_in),
    .i_valid_in (i_valid_in),
    .i_ready_out(i_ready_out),
    .o_data_out (o_data_out),
    .o_valid_out(o_valid_out),
    .o_ready_in (o_ready_in),
    .o_owner    (o_owner),
    .o_busy     (o_busy),
    .o_wdog_err (o_wdog_err)
  );

  typedef struct {
    logic [3:0] v, h, t;
    logic       rdy, rst;
    int         seq;
    logic       busy;
    logic [1:0] own;
    logic [3:0] rdyo;
    logic       wd;
  } vec_t;

  function automatic vec_t mkv(logic [3:0] v, logic [3:0] h, logic [3:0] t, logic rdy,
                               logic rst, int seq, logic busy, logic [1:0] own,
                               logic [3:0] rdyo, logic wd);
    vec_t r;
    r.v = v; r.h = h; r.t = t; r.rdy = rdy; r.rst = rst; r.seq = seq;
    r.busy = busy; r.own = own; r.rdyo = rdyo; r.wd = wd;
    return r;
  endfunction

  // Sets the quarter control bits; other sop bits in quarters 0-2 keep payload noise.
  function automatic logic [W-1:0] set_ctl(logic [W-1:0] fin, bit h, bit t, int eq);
    logic [W-1:0] f;
    f = fin;
    for (int q = 0; q < 4; q++) begin
      f[10'(q*150+149)] = 1'b1;
      f[10'(q*150+147)] = 1'b0;
    end
    f[598] = h;
    if (t) f[10'(eq*150+147)] = 1'b1;
    return f;
  endfunction

  function automatic logic [W-1:0] mk_flit(int src, int seq, bit h, bit t);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < 18; i++) f[10'(i*32) +: 32] = {8'(src), 8'(seq), 16'(i*40503 + seq*13)};
    f[599:576] = {8'(src), 16'(seq)};
    return set_ctl(f, h, t, (seq + src) % 4);
  endfunction

  function automatic logic [W-1:0] rnd_flit(bit h, bit t);
    logic [W-1:0] f;
    for (int i = 0; i < 18; i++) f[10'(i*32) +: 32] = $urandom;
    f[599:576] = 24'($urandom);
    return set_ctl(f, h, t, int'($urandom_range(0, 3)));
  endfunction

  function automatic int rr_first(logic [3:0] req, int ptr, int excl);
    for (int d = 1; d <= N; d++) begin
      int k;
      k = (ptr + d) % N;
      if (req[2'(k)] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic chk_s(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t r);
    logic [W-1:0] ed;
    reset      = r.rst;
    i_valid_in = r.v;
    o_ready_in = r.rdy;
    for (int k = 0; k < N; k++) i_data_in[12'(k*W) +: W] = mk_flit(k, r.seq, r.h[k], r.t[k]);
    ed = r.busy ? mk_flit(int'(r.own), r.seq, r.h[r.own], r.t[r.own]) : '0;
    @(negedge clk);
    chk_s("busy", int'(o_busy), int'(r.busy));
    chk_s("owner", int'(o_owner), int'(r.own));
    chk_s("valid", int'(o_valid_out), int'(r.busy && r.v[r.own]));
    chk_s("ready", int'(i_ready_out), int'(r.rdyo));
    chk_s("wdog", int'(o_wdog_err), int'(r.wd));
    chk_d("data", o_data_out, ed);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // Reference model state
  bit   m_busy, m_wd;
  int   m_owner, m_ptr, m_cnt;
  int   pos[N], len[N];
  logic [W-1:0] cur[N];
  bit   hd[N], tl[N];

  initial begin
    // v, h, t, rdy, rst, seq | busy, own, rdyo, wd
    tbl.push_back(mkv(4'b0101, 4'b0101, 4'b0000, 1, 0,  1, 0, 0, 4'b0000, 0));
    tbl.push_back(mkv(4'b0101, 4'b0101, 4'b0000, 1, 0,  2, 1, 0, 4'b0001, 0));
    tbl.push_back(mkv(4'b0101, 4'b0100, 4'b0000, 1, 0,  3, 1, 0, 4'b0001, 0));
    tbl.push_back(mkv(4'b0101, 4'b0100, 4'b0001, 1, 0,  4, 1, 0, 4'b0001, 0));
    tbl.push_back(mkv(4'b0100, 4'b0100, 4'b0000, 1, 0,  5, 1, 2, 4'b0100, 0));
    tbl.push_back(mkv(4'b0100, 4'b0000, 4'b0000, 1, 0,  6, 1, 2, 4'b0100, 0));
    tbl.push_back(mkv(4'b0100, 4'b0000, 4'b0100, 1, 0,  7, 1, 2, 4'b0100, 0));
    tbl.push_back(mkv(4'b0000, 4'b0000, 4'b0000, 1, 0,  8, 0, 2, 4'b0000, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0,  9, 0, 2, 4'b0000, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0, 10, 1, 3, 4'b1000, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0, 11, 1, 0, 4'b0001, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0, 12, 1, 1, 4'b0010, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0, 13, 1, 2, 4'b0100, 0));
    tbl.push_back(mkv(4'b1111, 4'b1111, 4'b1111, 1, 0, 14, 1, 3, 4'b1000, 0));
    tbl.push_back(mkv(4'b0001, 4'b0001, 4'b0001, 1, 0, 15, 1, 0, 4'b0001, 0));
    tbl.push_back(mkv(4'b0001, 4'b0000, 4'b0000, 1, 0, 16, 0, 0, 4'b0000, 0));
    tbl.push_back(mkv(4'b0001, 4'b0000, 4'b0000, 1, 0, 17, 0, 0, 4'b0000, 0));
    tbl.push_back(mkv(4'b1010, 4'b1010, 4'b1000, 1, 0, 18, 0, 0, 4'b0000, 0));
    tbl.push_back(mkv(4'b1010, 4'b1010, 4'b1000, 1, 0, 19, 1, 1, 4'b0010, 0));
    tbl.push_back(mkv(4'b1010, 4'b1000, 4'b1000, 1, 0, 20, 1, 1, 4'b0010, 0));
    tbl.push_back(mkv(4'b1010, 4'b1000, 4'b1010, 0, 0, 21, 1, 1, 4'b0000, 0));
    tbl.push_back(mkv(4'b1010, 4'b1000, 4'b1010, 0, 0, 21, 1, 1, 4'b0000, 0));
    tbl.push_back(mkv(4'b1010, 4'b1000, 4'b1010, 1, 0, 21, 1, 1, 4'b0010, 0));
    tbl.push_back(mkv(4'b1000, 4'b1000, 4'b1000, 1, 0, 22, 1, 3, 4'b1000, 0));
    tbl.push_back(mkv(4'b0000, 4'b0000, 4'b0000, 1, 0, 23, 0, 3, 4'b0000, 0));

    reset = 1'b1; i_valid_in = '0; o_ready_in = 1'b0; i_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // Reset in the middle of a packet; the pointer must return to its reset value.
    run(mkv(4'b0001, 4'b0001, 4'b0001, 1, 0, 30, 0, 3, 4'b0000, 0));
    run(mkv(4'b0001, 4'b0001, 4'b0001, 1, 0, 31, 1, 0, 4'b0001, 0));
    run(mkv(4'b0100, 4'b0100, 4'b0000, 1, 0, 32, 0, 0, 4'b0000, 0));
    run(mkv(4'b0100, 4'b0100, 4'b0000, 1, 0, 33, 1, 2, 4'b0100, 0));
    run(mkv(4'b0100, 4'b0000, 4'b0000, 1, 1, 34, 1, 2, 4'b0100, 0));
    run(mkv(4'b0111, 4'b0111, 4'b0000, 1, 0, 35, 0, 0, 4'b0000, 0));
    run(mkv(4'b0111, 4'b0111, 4'b0001, 1, 0, 36, 1, 0, 4'b0001, 0));
    run(mkv(4'b0000, 4'b0000, 4'b0000, 1, 0, 37, 1, 1, 4'b0010, 0));
    run(mkv(4'b0010, 4'b0010, 4'b0010, 1, 0, 38, 1, 1, 4'b0010, 0));
    run(mkv(4'b0000, 4'b0000, 4'b0000, 1, 1, 39, 0, 1, 4'b0000, 0));

    if (Wdog) begin
      // Input 2 streams tail-less flits; the fourth transfer forces handover to 3.
      run(mkv(4'b1100, 4'b1100, 4'b0000, 1, 0, 40, 0, 0, 4'b0000, 0));
      run(mkv(4'b1100, 4'b1100, 4'b0000, 1, 0, 41, 1, 2, 4'b0100, 0));
      run(mkv(4'b1100, 4'b1000, 4'b0000, 1, 0, 42, 1, 2, 4'b0100, 0));
      run(mkv(4'b1100, 4'b1000, 4'b0000, 1, 0, 43, 1, 2, 4'b0100, 0));
      run(mkv(4'b1100, 4'b1000, 4'b0000, 1, 0, 44, 1, 2, 4'b0100, 0));
      run(mkv(4'b1100, 4'b1000, 4'b1000, 1, 0, 45, 1, 3, 4'b1000, 1));
      run(mkv(4'b0100, 4'b0000, 4'b0000, 1, 0, 46, 0, 3, 4'b0000, 0));
      run(mkv(4'b0100, 4'b0000, 4'b0000, 1, 0, 47, 0, 3, 4'b0000, 0));
    end

    // Randomized packet sources against the reference model.
    reset = 1'b1; i_valid_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_busy = 0; m_wd = 0; m_owner = 0; m_ptr = N - 1; m_cnt = 0;
    for (int k = 0; k < N; k++) begin
      len[k] = int'($urandom_range(1, 6)); pos[k] = 0;
      hd[k] = 1; tl[k] = (len[k] == 1); cur[k] = rnd_flit(hd[k], tl[k]);
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] vv, req, erdy;
      logic rr;
      int own, w;
      bit wd_n;
      for (int k = 0; k < N; k++) begin
        vv[k] = ($urandom_range(0, 99) < 70);
        req[k] = vv[k] && hd[k];
        i_data_in[12'(k*W) +: W] = cur[k];
      end
      rr = ($urandom_range(0, 3) != 0);
      i_valid_in = vv; o_ready_in = rr;
      own  = m_owner;
      erdy = m_busy ? (4'(rr) << own) : 4'b0000;
      @(negedge clk);
      chk_s("r_busy", int'(o_busy), int'(m_busy));
      chk_s("r_owner", int'(o_owner), own);
      chk_s("r_valid", int'(o_valid_out), int'(m_busy && vv[2'(own)]));
      chk_s("r_ready", int'(i_ready_out), int'(erdy));
      chk_s("r_wdog", int'(o_wdog_err), int'(m_wd));
      chk_d("r_data", o_data_out, m_busy ? cur[own] : '0);

      wd_n = 0;
      if (!m_busy) begin
        w = rr_first(req, m_ptr, -1);
        if (w >= 0) begin m_busy = 1; m_owner = w; m_cnt = 0; end
      end else if (vv[2'(own)] && rr) begin
        m_cnt++;
        if (Wdog && m_cnt == MaxFl && !tl[own]) wd_n = 1;
        if (tl[own] || wd_n) begin
          m_ptr = own;
          w = rr_first(req, own, own);
          if (w >= 0) begin m_owner = w; m_cnt = 0; end
          else m_busy = 0;
        end
      end
      m_wd = wd_n;

      for (int k = 0; k < N; k++) begin
        if (vv[k] && erdy[k]) begin
          if (pos[k] == len[k] - 1) begin
            pos[k] = 0; len[k] = int'($urandom_range(1, 6));
          end else begin
            pos[k]++;
          end
          hd[k] = (pos[k] == 0); tl[k] = (pos[k] == len[k] - 1);
          cur[k] = rnd_flit(hd[k], tl[k]);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
